// File: rtl/seq_divider8_if.sv
// Divide request/response bundle: controller drives start and operands, divider returns status and results.
// Controller side uses the master modport; the divider uses the slave modport.
interface seq_divider8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider, one shift-and-trial-subtract per cycle; done WIDTH+1 edges after accept (1 for /0).
// No queueing: start is only taken while busy=0, and starts arriving during RUN are dropped.
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] diff;
    logic             carry;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             last;
    logic             r_msb_unused;

    // Subtract as T + ~D + 1; the carry out means T >= D (no borrow).
    assign t      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff   = {1'b0, t} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry  = diff[WIDTH+1];
    assign r_next = carry ? diff[WIDTH:0] : t;
    assign q_next = {q_q[WIDTH-2:0], carry};
    assign last   = (cnt_q == CW'(WIDTH-1));

    // R stays below D, so its top bit is always zero and never feeds T.
    assign r_msb_unused = r_q[WIDTH];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                q_d    = q_next;
                r_d    = r_next;
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = q_next;
                    rem_d   = r_next[WIDTH-1:0];
                end
            end
            default: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_d = RUN;
                        q_d     = bus.dividend;
                        r_d     = '0;
                        d_d     = bus.divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider8.sv
// Directed and random checks of seq_divider8 (WIDTH=8) against hand-computed values and a reference model.
module tb_seq_divider8;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_divider8_if #(.WIDTH(8)) bus ();

    seq_divider8 #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, then tracks edges (accepting edge = 1) until done.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat, output int bsy);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 1;
        bsy = int'(bus.busy);
        while (!bus.done && lat < 20) begin
            tick;
            lat++;
            bsy += int'(bus.busy);
        end
    endtask

    logic [7:0] vec_a [4] = '{8'd255, 8'd255, 8'd7, 8'd0};
    logic [7:0] vec_b [4] = '{8'd1, 8'd255, 8'd9, 8'd5};
    logic [7:0] vec_q [4] = '{8'd255, 8'd1, 8'd0, 8'd0};
    logic [7:0] vec_r [4] = '{8'd0, 8'd0, 8'd7, 8'd0};

    initial begin
        int lat;
        int bsy;
        int n;
        int seen;
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quo", bus.quotient, 0);
        check("rst_rem", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Basic divide
        run_div(8'd36, 8'd24, lat, bsy);
        check("basic_lat", lat, 9);
        check("basic_busy", bsy, 8);
        check("basic_quo", bus.quotient, 1);
        check("basic_rem", bus.remainder, 12);
        check("basic_dbz", bus.div_by_zero, 0);
        tick;
        check("basic_done_pulse", bus.done, 0);
        check("basic_hold_quo", bus.quotient, 1);

        // Extremes
        for (int i = 0; i < 4; i++) begin
            run_div(vec_a[i], vec_b[i], lat, bsy);
            check("ext_lat", lat, 9);
            check("ext_quo", bus.quotient, 32'(vec_q[i]));
            check("ext_rem", bus.remainder, 32'(vec_r[i]));
        end

        // Divide by zero, then a normal divide clears the flag
        tick;
        run_div(8'd100, 8'd0, lat, bsy);
        check("dz_lat", lat, 1);
        check("dz_busy", bsy, 0);
        check("dz_quo", bus.quotient, 255);
        check("dz_rem", bus.remainder, 100);
        check("dz_flag", bus.div_by_zero, 1);
        run_div(8'd10, 8'd3, lat, bsy);
        check("after_dz_lat", lat, 9);
        check("after_dz_flag", bus.div_by_zero, 0);
        check("after_dz_quo", bus.quotient, 3);
        check("after_dz_rem", bus.remainder, 1);

        // Start while busy is ignored
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        tick;
        n = 1;
        bus.start = 1'b0;
        tick;
        tick;
        n += 2;
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        tick;
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 20) begin
            tick;
            n++;
        end
        check("ignore_lat", n, 9);
        check("ignore_quo", bus.quotient, 28);
        check("ignore_rem", bus.remainder, 4);

        // Back-to-back: start held from the done cycle onwards
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        tick;
        n = 1;
        check("b2b_done_once", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
        check("b2b_hold_quo", bus.quotient, 28);
        check("b2b_hold_rem", bus.remainder, 4);
        while (!bus.done && n < 20) begin
            tick;
            n++;
        end
        bus.start = 1'b0;
        check("b2b_lat", n, 9);
        check("b2b_quo", bus.quotient, 10);
        check("b2b_rem", bus.remainder, 0);

        // Reset in the middle of a run
        tick;
        bus.start    = 1'b1;
        bus.dividend = 8'd123;
        bus.divisor  = 8'd4;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_quo", bus.quotient, 0);
        check("mid_rst_rem", bus.remainder, 0);
        check("mid_rst_dbz", bus.div_by_zero, 0);
        tick;
        tick;
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            seen += int'(bus.done);
        end
        check("no_done_after_rst", seen, 0);
        run_div(8'd123, 8'd4, lat, bsy);
        check("post_rst_lat", lat, 9);
        check("post_rst_quo", bus.quotient, 30);
        check("post_rst_rem", bus.remainder, 3);

        // Random operands against a reference model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            int ia;
            int ib;
            a  = 8'($urandom);
            b  = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            ia = int'(a);
            ib = int'(b);
            run_div(a, b, lat, bsy);
            if (ib == 0) begin
                check("rnd_lat0", lat, 1);
                check("rnd_quo0", bus.quotient, 255);
                check("rnd_rem0", bus.remainder, 32'(ia));
                check("rnd_dbz0", bus.div_by_zero, 1);
            end else begin
                check("rnd_lat", lat, 9);
                check("rnd_quo", bus.quotient, 32'(ia / ib));
                check("rnd_rem", bus.remainder, 32'(ia % ib));
                check("rnd_dbz", bus.div_by_zero, 0);
                check("rnd_ident",
                      32'((int'(bus.quotient) * ib + int'(bus.remainder) == ia)
                          && (int'(bus.remainder) < ib)), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
